// File: rtl/sop_sweep_ctrl.sv
// rtl/sop_sweep_ctrl.sv - truth-table sweep sequencer for the decoder-based SOP unit
//
// Holds an 8-bit minterm mask, steps a 3-to-8 decoder through {A,B,C} = 0..7,
// evaluates F = OR(dec_out & mask) at each step and returns the assembled truth
// table through a valid/ready handshake.
//
// Parameters:
//   STEP_CYCLES  dwell cycles per input combination (>= 1)
//   INIT_MASK    mask value loaded on reset
//
// Ports:
//   clk         in   clock, rising edge
//   rst         in   asynchronous active-high reset
//   cfg_we      in   mask write strobe (accepted in IDLE only)
//   cfg_mask    in   [7:0] new minterm mask
//   start       in   begin a sweep (accepted in IDLE only)
//   busy        out  high in SWEEP and DONE
//   abc         out  [2:0] current input combination (A = bit 2)
//   dec_out     out  [7:0] one-hot decode of abc during SWEEP, else 0
//   f           out  OR(dec_out & mask)
//   res_valid   out  truth table available (DONE)
//   res_ready   in   consumer accepts the table
//   result      out  [7:0] truth table, result[n] = F for {A,B,C} = n
//   cfg_err     out  one-cycle pulse for a mask write attempted while busy
//   ones_count  out  [3:0] popcount of result (only with SOP_ONES_COUNT_EN)
//
// Optional feature macro: SOP_ONES_COUNT_EN

module sop_sweep_ctrl #(
  parameter int         STEP_CYCLES = 1,
  parameter logic [7:0] INIT_MASK   = 8'h00
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cfg_we,
  input  logic [7:0] cfg_mask,
  input  logic       start,
  output logic       busy,
  output logic [2:0] abc,
  output logic [7:0] dec_out,
  output logic       f,
  output logic       res_valid,
  input  logic       res_ready,
  output logic [7:0] result,
  output logic       cfg_err
`ifdef SOP_ONES_COUNT_EN
  ,
  output logic [3:0] ones_count
`endif
);

  localparam int DW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [DW-1:0] DWELL_LAST = DW'(STEP_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SWEEP = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [2:0]    abc_q, abc_d;
  logic [DW-1:0] dwell_q, dwell_d;
  logic [7:0]    result_q, result_d;
  logic [7:0]    mask_q, mask_d;
  logic          cfg_err_q, cfg_err_d;
  logic          enter_done;
  logic          sweep_start;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      abc_q     <= 3'd0;
      dwell_q   <= '0;
      result_q  <= 8'h00;
      mask_q    <= INIT_MASK;
      cfg_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      abc_q     <= abc_d;
      dwell_q   <= dwell_d;
      result_q  <= result_d;
      mask_q    <= mask_d;
      cfg_err_q <= cfg_err_d;
    end
  end

  // Decoder is only active while sweeping so F reads 0 outside a sweep.
  assign dec_out   = (state_q == S_SWEEP) ? (8'b1 << abc_q) : 8'h00;
  assign f         = |(dec_out & mask_q);
  assign busy      = (state_q != S_IDLE);
  assign res_valid = (state_q == S_DONE);
  assign abc       = abc_q;
  assign result    = result_q;
  assign cfg_err   = cfg_err_q;

  always_comb begin
    state_d     = state_q;
    abc_d       = abc_q;
    dwell_d     = dwell_q;
    result_d    = result_q;
    mask_d      = mask_q;
    cfg_err_d   = 1'b0;
    enter_done  = 1'b0;
    sweep_start = 1'b0;

    // Mask writes only land in IDLE; the same-edge start then uses the new mask.
    if (cfg_we) begin
      if (state_q == S_IDLE) mask_d = cfg_mask;
      else                   cfg_err_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d     = S_SWEEP;
          abc_d       = 3'd0;
          dwell_d     = '0;
          result_d    = 8'h00;
          sweep_start = 1'b1;
        end
      end
      S_SWEEP: begin
        if (dwell_q == DWELL_LAST) begin
          dwell_d         = '0;
          result_d[abc_q] = f;
          if (abc_q == 3'd7) begin
            state_d    = S_DONE;
            enter_done = 1'b1;
          end else begin
            abc_d = abc_q + 3'd1;
          end
        end else begin
          dwell_d = dwell_q + DW'(1);
        end
      end
      S_DONE: begin
        if (res_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

`ifdef SOP_ONES_COUNT_EN
  logic [3:0] ones_q;

  // Captured from the final table as DONE is entered, cleared on the next start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ones_q <= 4'd0;
    end else if (sweep_start) begin
      ones_q <= 4'd0;
    end else if (enter_done) begin
      ones_q <= 4'($countones(result_d));
    end
  end

  assign ones_count = ones_q;
`else
  // Without the popcount feature the sweep-start and DONE-entry strobes have no
  // consumer; fold them into a dead signal so they stay referenced.
  logic unused_strobes;
  assign unused_strobes = enter_done ^ sweep_start;
`endif

endmodule

// File: tb/tb_sop_sweep_ctrl.sv
// tb/tb_sop_sweep_ctrl.sv - scoreboard testbench for sop_sweep_ctrl
module tb_sop_sweep_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // DUT A: STEP_CYCLES=1, non-zero INIT_MASK so the reset restore is visible
  logic       cfg_we, start, res_ready;
  logic [7:0] cfg_mask;
  logic       busy, f, res_valid, cfg_err;
  logic [2:0] abc;
  logic [7:0] dec_out, result;
  logic [3:0] ones_count;

  // DUT B: STEP_CYCLES=3
  logic       b_cfg_we, b_start, b_res_ready;
  logic [7:0] b_cfg_mask;
  logic       b_busy, b_f, b_res_valid, b_cfg_err;
  logic [2:0] b_abc;
  logic [7:0] b_dec_out, b_result;
  logic [3:0] b_ones_count;

  logic [7:0] exp_q[$];
  logic [7:0] b_exp_q[$];

  sop_sweep_ctrl #(.STEP_CYCLES(1), .INIT_MASK(8'h5A)) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_mask(cfg_mask), .start(start),
    .busy(busy), .abc(abc), .dec_out(dec_out), .f(f), .res_valid(res_valid),
    .res_ready(res_ready), .result(result), .cfg_err(cfg_err)
`ifdef SOP_ONES_COUNT_EN
    , .ones_count(ones_count)
`endif
  );

  sop_sweep_ctrl #(.STEP_CYCLES(3), .INIT_MASK(8'h00)) dut_b (
    .clk(clk), .rst(rst), .cfg_we(b_cfg_we), .cfg_mask(b_cfg_mask), .start(b_start),
    .busy(b_busy), .abc(b_abc), .dec_out(b_dec_out), .f(b_f), .res_valid(b_res_valid),
    .res_ready(b_res_ready), .result(b_result), .cfg_err(b_cfg_err)
`ifdef SOP_ONES_COUNT_EN
    , .ones_count(b_ones_count)
`endif
  );

`ifndef SOP_ONES_COUNT_EN
  assign ones_count   = 4'd0;
  assign b_ones_count = 4'd0;
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] pop8(input logic [7:0] v);
    logic [3:0] n = 4'd0;
    for (int i = 0; i < 8; i++) n += {3'd0, v[i]};
    return n;
  endfunction

  // Monitors: compare each accepted table against the scoreboard.
  always @(negedge clk) begin
    if (!rst && res_valid && res_ready) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL sb_a_unexpected actual=%0h expected=none", result);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        check("sb_a_result", {24'd0, result}, {24'd0, e});
`ifdef SOP_ONES_COUNT_EN
        check("sb_a_ones", {28'd0, ones_count}, {28'd0, pop8(e)});
`endif
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && b_res_valid && b_res_ready) begin
      if (b_exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL sb_b_unexpected actual=%0h expected=none", b_result);
      end else begin
        logic [7:0] e;
        e = b_exp_q.pop_front();
        check("sb_b_result", {24'd0, b_result}, {24'd0, e});
`ifdef SOP_ONES_COUNT_EN
        check("sb_b_ones", {28'd0, b_ones_count}, {28'd0, pop8(e)});
`endif
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_mask(input logic [7:0] m);
    cfg_we = 1'b1; cfg_mask = m;
    tick();
    cfg_we = 1'b0;
  endtask

  // Issues start; returns in cycle 1 of the sweep.
  task automatic go();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // From cycle cyc, advance until res_valid or the budget runs out.
  task automatic wait_valid(inout int cyc);
    while (!res_valid && cyc < 200) begin
      tick();
      cyc++;
    end
  endtask

  int cyc;
  logic [7:0] xor_mask;

  initial begin
    rst = 1'b1;
    cfg_we = 0; cfg_mask = 0; start = 0; res_ready = 1;
    b_cfg_we = 0; b_cfg_mask = 0; b_start = 0; b_res_ready = 1;
    #23;
    // Reset state
    check("rst_busy", busy, 0);
    check("rst_abc", abc, 0);
    check("rst_dec", dec_out, 0);
    check("rst_f", f, 0);
    check("rst_valid", res_valid, 0);
    check("rst_result", result, 0);
    check("rst_cfg_err", cfg_err, 0);
    check("rst_ones", ones_count, 0);
    @(negedge clk);
    rst = 1'b0;
    tick();

    // XOR function, with f sequence and latency
    xor_mask = 8'h96;
    write_mask(xor_mask);
    exp_q.push_back(8'h96);
    go();
    cyc = 1;
    check("xor_busy_c1", busy, 1);
    for (int k = 0; k < 8; k++) begin
      check("xor_abc", abc, k);
      check("xor_f", f, xor_mask[k]);
      check("xor_valid_low", res_valid, 0);
      tick();
      cyc++;
    end
    check("xor_latency", cyc, 9);
    check("xor_valid", res_valid, 1);
    check("xor_dec_done", dec_out, 0);
    tick();
    check("xor_idle_busy", busy, 0);
    check("xor_abc_hold", abc, 7);

    // Backpressure
    res_ready = 1'b0;
    write_mask(8'hA5);
    exp_q.push_back(8'hA5);
    go();
    cyc = 1;
    wait_valid(cyc);
    check("bp_latency", cyc, 9);
    for (int k = 0; k < 10; k++) begin
      check("bp_result_stable", result, 8'hA5);
      check("bp_busy", busy, 1);
      check("bp_valid", res_valid, 1);
      tick();
    end
    res_ready = 1'b1;
    tick();
    check("bp_valid_fall", res_valid, 0);
    check("bp_busy_fall", busy, 0);

    // Busy write during sweep
    write_mask(8'h0F);
    exp_q.push_back(8'h0F);
    go();
    tick(); tick(); tick();  // cycle 4
    check("bw_err_before", cfg_err, 0);
    cfg_we = 1'b1; cfg_mask = 8'hFF;
    tick();
    cfg_we = 1'b0;
    check("bw_err_pulse", cfg_err, 1);
    tick();
    check("bw_err_clear", cfg_err, 0);
    cyc = 6;
    wait_valid(cyc);
    check("bw_latency", cyc, 9);
    check("bw_result", result, 8'h0F);
    tick();

    // Simultaneous write and start
    exp_q.push_back(8'h3C);
    cfg_we = 1'b1; cfg_mask = 8'h3C; start = 1'b1;
    tick();
    cfg_we = 1'b0; start = 1'b0;
    cyc = 1;
    wait_valid(cyc);
    check("ws_latency", cyc, 9);
    tick();

    // res_ready and start together in DONE: start dropped
    res_ready = 1'b0;
    write_mask(8'h01);
    exp_q.push_back(8'h01);
    go();
    cyc = 1;
    wait_valid(cyc);
    res_ready = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    check("rs_idle", busy, 0);
    tick(); tick();
    check("rs_no_restart", busy, 0);

    // Reset mid-sweep
    write_mask(8'h33);
    go();
    tick(); tick(); tick(); tick();  // cycle 5
    rst = 1'b1;
    #1;
    check("mr_busy", busy, 0);
    check("mr_abc", abc, 0);
    check("mr_dec", dec_out, 0);
    check("mr_f", f, 0);
    check("mr_valid", res_valid, 0);
    check("mr_result", result, 0);
    check("mr_cfg_err", cfg_err, 0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    exp_q.push_back(8'h5A);
    go();
    cyc = 1;
    wait_valid(cyc);
    check("mr_resweep_latency", cyc, 9);
    tick();

    // Dwell: STEP_CYCLES=3
    b_cfg_we = 1'b1; b_cfg_mask = 8'h80;
    tick();
    b_cfg_we = 1'b0;
    b_exp_q.push_back(8'h80);
    b_start = 1'b1;
    tick();
    b_start = 1'b0;
    cyc = 1;
    for (int k = 1; k <= 24; k++) begin
      check("dw_abc", b_abc, (k - 1) / 3);
      check("dw_f", b_f, ((k - 1) / 3) == 7);
      tick();
      cyc++;
    end
    check("dw_valid", b_res_valid, 1);
    check("dw_latency", cyc, 25);
    tick();
    check("dw_idle", b_busy, 0);

    tick(); tick();
    check("sb_a_drained", exp_q.size(), 0);
    check("sb_b_drained", b_exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
